// File: rtl/rssb_mc.sv
`default_nettype none
// ============================================================================
// Module   : rssb_mc
// Purpose  : Parametrised multi-cycle RSSB (reverse-subtract-and-skip-if-
//            borrow) processor core with an internal program memory, start /
//            single-step control, a halt word, a zero register at address 0
//            and a memory-mapped output port at address 1.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            start, step           - run / single-instruction request (IDLE)
//            prog_we/addr/data     - program-memory write port (IDLE/HALTED)
//            busy, halted          - FSM status
//            out_valid, out_data   - output-port strobe and held value
//            opc, oacc, oop1,      - debug view: PC, accumulator, operand
//            omem, osub            -   address, operand value, last result
//            icount                - executed-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module rssb_mc #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int START_PC = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic             prog_we,
   input  logic [AW-1:0]    prog_addr,
   input  logic [WIDTH-1:0] prog_data,
   output logic             busy,
   output logic             halted,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    opc,
   output logic [WIDTH-1:0] oacc,
   output logic [AW-1:0]    oop1,
   output logic [WIDTH-1:0] omem,
   output logic [WIDTH-1:0] osub,
   output logic [15:0]      icount
);

   localparam logic [AW-1:0]    c_zero_addr = '0;
   localparam logic [AW-1:0]    c_out_addr  = AW'(1);
   localparam logic [AW-1:0]    c_pc_one    = AW'(1);
   localparam logic [AW-1:0]    c_pc_two    = AW'(2);
   localparam logic [AW-1:0]    c_start_pc  = AW'(START_PC);
   localparam logic [WIDTH-1:0] c_halt_word = {WIDTH{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_READ   = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_pc;
   logic [AW-1:0]    r_op1;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_opv;
   logic [WIDTH-1:0] r_sub;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_step_mode;
   logic [15:0]      r_icount;

   logic [WIDTH-1:0] w_word;
   logic             w_halt_word;
   logic [WIDTH-1:0] w_diff;
   logic             w_borrow;
   logic             w_op_zero;
   logic             w_prog_ok;

   // Fetch reads the raw array, so address 0 is only "zero" as an operand.
   assign w_word      = r_mem[r_pc];
   assign w_halt_word = (w_word == c_halt_word);
   assign w_diff      = r_opv - r_acc;
   assign w_borrow    = (r_opv < r_acc);
   assign w_op_zero   = (r_op1 == c_zero_addr);
   assign w_prog_ok   = prog_we && (prog_addr != c_zero_addr) &&
                        ((r_state == S_IDLE) || (r_state == S_HALTED));

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start || step) w_next = S_FETCH;
         S_FETCH:  w_next = w_halt_word ? S_HALTED : S_READ;
         S_READ:   w_next = S_EXEC;
         S_EXEC:   w_next = r_step_mode ? S_IDLE : S_FETCH;
         S_HALTED: w_next = S_HALTED;
         default:  w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= c_start_pc;
         r_op1       <= '0;
         r_acc       <= '0;
         r_opv       <= '0;
         r_sub       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_step_mode <= 1'b0;
         r_icount    <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // start wins over step when both are high
               if (start)     r_step_mode <= 1'b0;
               else if (step) r_step_mode <= 1'b1;
            end
            S_FETCH: begin
               if (!w_halt_word) r_op1 <= w_word[AW-1:0];
            end
            S_READ: begin
               r_opv <= w_op_zero ? '0 : r_mem[r_op1];
            end
            S_EXEC: begin
               r_sub    <= w_diff;
               r_acc    <= w_diff;
               r_pc     <= r_pc + (w_borrow ? c_pc_two : c_pc_one);
               r_icount <= r_icount + 16'd1;
               if (r_op1 == c_out_addr) begin
                  r_out_data  <= w_diff;
                  r_out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory is never cleared; reset only suppresses writes in its cycle,
   // which is what aborts an in-flight instruction and drops a prog write.
   // EXEC and the program port can never collide (different states).
   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((r_state == S_EXEC) && !w_op_zero) r_mem[r_op1]     <= w_diff;
         else if (w_prog_ok)                    r_mem[prog_addr] <= prog_data;
      end
   end

   assign busy      = (r_state == S_FETCH) || (r_state == S_READ) ||
                      (r_state == S_EXEC);
   assign halted    = (r_state == S_HALTED);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign opc       = r_pc;
   assign oacc      = r_acc;
   assign oop1      = r_op1;
   assign omem      = r_opv;
   assign osub      = r_sub;
   assign icount    = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_rssb_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rssb_mc
// Purpose  : Directed self-checking bench for rssb_mc (WIDTH=8, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rssb_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       step = 1'b0;
   logic       prog_we = 1'b0;
   logic [3:0] prog_addr = '0;
   logic [7:0] prog_data = '0;
   logic       busy, halted, out_valid;
   logic [7:0] out_data, oacc, omem, osub;
   logic [3:0] opc, oop1;
   logic [15:0] icount;

   int n_tests = 0;
   int n_fail  = 0;

   rssb_mc #(.WIDTH(8), .DEPTH(16), .START_PC(2)) dut (
      .clk(clk), .rst(rst), .start(start), .step(step),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .busy(busy), .halted(halted), .out_valid(out_valid),
      .out_data(out_data), .opc(opc), .oacc(oacc), .oop1(oop1),
      .omem(omem), .osub(osub), .icount(icount)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   // Pulse step and wait for the instruction to complete (back in IDLE).
   task automatic do_step();
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (opc !== 4'd2) begin n_fail++; $display("FAIL reset_pc: got %0h want 2", opc); end
      n_tests++; if ({oacc, omem, osub, out_data} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {oacc, omem, osub, out_data}); end
      n_tests++; if ({oop1, icount} !== 20'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", {oop1, icount}); end
      n_tests++; if ({busy, halted, out_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, halted, out_valid}); end
   endtask

   task automatic test_basic_step();
      load(4'd2, 8'h08);
      load(4'd8, 8'h05);
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL step_busy%0d: got %b want 1", i, busy); end
         tick();
      end
      n_tests++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL step_idle: got busy=%b halted=%b want 0 0", busy, halted); end
      n_tests++; if (oacc !== 8'h05 || osub !== 8'h05) begin n_fail++; $display("FAIL step_acc: got acc=%h sub=%h want 05 05", oacc, osub); end
      n_tests++; if (opc !== 4'd3) begin n_fail++; $display("FAIL step_pc: got %0d want 3", opc); end
      n_tests++; if (icount !== 16'd1) begin n_fail++; $display("FAIL step_icount: got %0d want 1", icount); end
      n_tests++; if (dut.r_mem[8] !== 8'h05) begin n_fail++; $display("FAIL step_mem: got %h want 05", dut.r_mem[8]); end
   endtask

   task automatic test_borrow();
      load(4'd3, 8'h09);
      load(4'd9, 8'h03);
      do_step();
      n_tests++; if (oacc !== 8'hFE || osub !== 8'hFE) begin n_fail++; $display("FAIL borrow_acc: got acc=%h sub=%h want fe fe", oacc, osub); end
      n_tests++; if (opc !== 4'd5) begin n_fail++; $display("FAIL borrow_pc: got %0d want 5", opc); end
      n_tests++; if (dut.r_mem[9] !== 8'hFE) begin n_fail++; $display("FAIL borrow_mem: got %h want fe", dut.r_mem[9]); end
      n_tests++; if (icount !== 16'd2) begin n_fail++; $display("FAIL borrow_icount: got %0d want 2", icount); end
   endtask

   task automatic test_zero_reg();
      // 0 - 0xFE = 0x02 with borrow: acc becomes 2, pc 5 -> 7
      load(4'd5, 8'h0A);
      load(4'd10, 8'h00);
      load(4'd7, 8'h00);
      do_step();
      n_tests++; if (oacc !== 8'h02 || opc !== 4'd7) begin n_fail++; $display("FAIL zero_setup: got acc=%h pc=%0d want 02 7", oacc, opc); end
      do_step();
      n_tests++; if (osub !== 8'hFE || oacc !== 8'hFE) begin n_fail++; $display("FAIL zero_sub: got sub=%h acc=%h want fe fe", osub, oacc); end
      n_tests++; if (opc !== 4'd9) begin n_fail++; $display("FAIL zero_pc: got %0d want 9", opc); end
      n_tests++; if (omem !== 8'h00) begin n_fail++; $display("FAIL zero_read: got %h want 00", omem); end
      load(4'd0, 8'hFF);
      n_tests++; if (dut.r_mem[0] === 8'hFF) begin n_fail++; $display("FAIL zero_progwe: got %h want not ff", dut.r_mem[0]); end
      load(4'd9, 8'h00);
      do_step();
      n_tests++; if (omem !== 8'h00 || oacc !== 8'h02) begin n_fail++; $display("FAIL zero_reread: got mem=%h acc=%h want 00 02", omem, oacc); end
      n_tests++; if (opc !== 4'd11 || icount !== 16'd5) begin n_fail++; $display("FAIL zero_pc2: got pc=%0d cnt=%0d want 11 5", opc, icount); end
   endtask

   task automatic test_output_port();
      do_reset();
      load(4'd2, 8'h01);
      load(4'd1, 8'h07);
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_early%0d: got %b want 0", i, out_valid); end
         tick();
      end
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin n_fail++; $display("FAIL out_strobe: got v=%b d=%h want 1 07", out_valid, out_data); end
      tick();
      n_tests++; if (out_valid !== 1'b0 || out_data !== 8'h07) begin n_fail++; $display("FAIL out_hold: got v=%b d=%h want 0 07", out_valid, out_data); end
      n_tests++; if (dut.r_mem[1] !== 8'h07) begin n_fail++; $display("FAIL out_mem: got %h want 07", dut.r_mem[1]); end
   endtask

   task automatic test_run_to_halt();
      do_reset();
      load(4'd2, 8'h0B); load(4'd11, 8'h05);   // 5-0=5,  pc 3
      load(4'd3, 8'h0C); load(4'd12, 8'h09);   // 9-5=4,  pc 4
      load(4'd4, 8'h01); load(4'd1, 8'h06);    // 6-4=2 -> out, pc 5
      load(4'd5, 8'hFF);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 100 && !halted; k++) tick();
      n_tests++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL halt_state: got halted=%b busy=%b want 1 0", halted, busy); end
      n_tests++; if (icount !== 16'd3) begin n_fail++; $display("FAIL halt_icount: got %0d want 3", icount); end
      n_tests++; if (oacc !== 8'h02 || out_data !== 8'h02 || opc !== 4'd5) begin n_fail++; $display("FAIL halt_result: got acc=%h out=%h pc=%0d want 02 02 5", oacc, out_data, opc); end
      start = 1'b1; tick(); start = 1'b0; tick();
      step = 1'b1; tick(); step = 1'b0; tick(); tick(); tick();
      n_tests++; if (halted !== 1'b1 || busy !== 1'b0 || icount !== 16'd3 || opc !== 4'd5) begin n_fail++; $display("FAIL halt_sticky: got h=%b b=%b cnt=%0d pc=%0d want 1 0 3 5", halted, busy, icount, opc); end
      load(4'd13, 8'h3C);
      n_tests++; if (dut.r_mem[13] !== 8'h3C) begin n_fail++; $display("FAIL halt_progwe: got %h want 3c", dut.r_mem[13]); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      for (int a = 2; a < 16; a++) load(4'(a), 8'h00);
      for (int s = 0; s < 14; s++) do_step();   // pc 2..15, last step wraps
      n_tests++; if (opc !== 4'd0 || oacc !== 8'h00) begin n_fail++; $display("FAIL wrap_noborrow: got pc=%0d acc=%h want 0 00", opc, oacc); end
      do_reset();
      load(4'd14, 8'h5E);                       // self-read: acc = 0x5E
      for (int s = 0; s < 14; s++) do_step();
      n_tests++; if (opc !== 4'd1 || osub !== 8'hA2) begin n_fail++; $display("FAIL wrap_borrow: got pc=%0d sub=%h want 1 a2", opc, osub); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      load(4'd2, 8'h0B);
      load(4'd11, 8'h33);
      step = 1'b1; tick(); step = 1'b0;
      tick();                                   // now in READ
      do_reset();
      n_tests++; if (dut.r_mem[11] !== 8'h33 || opc !== 4'd2) begin n_fail++; $display("FAIL midrd_state: got mem=%h pc=%0d want 33 2", dut.r_mem[11], opc); end
      n_tests++; if ({oacc, omem, osub, out_data, oop1, icount, busy, out_valid} !== 54'h0) begin n_fail++; $display("FAIL midrd_zero: got %h want 0", {oacc, omem, osub, out_data, oop1, icount, busy, out_valid}); end
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick();                           // now in EXEC
      do_reset();
      n_tests++; if (dut.r_mem[11] !== 8'h33 || opc !== 4'd2 || icount !== 16'd0) begin n_fail++; $display("FAIL midex_state: got mem=%h pc=%0d cnt=%0d want 33 2 0", dut.r_mem[11], opc, icount); end
      rst = 1'b1; prog_we = 1'b1; prog_addr = 4'd11; prog_data = 8'h44;
      tick();
      rst = 1'b0; prog_we = 1'b0;
      n_tests++; if (dut.r_mem[11] !== 8'h33) begin n_fail++; $display("FAIL rst_drops_we: got %h want 33", dut.r_mem[11]); end
   endtask

   initial begin
      test_reset();
      test_basic_step();
      test_borrow();
      test_zero_reg();
      test_output_port();
      test_run_to_halt();
      test_pc_wrap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rssb_mc.md
# rssb_mc

Parametrised multi-cycle RSSB (reverse-subtract-and-skip-if-borrow) processor core, the successor to the fixed single-instruction `rssb` core. It adds several things the fixed core lacks:
- generic data width and memory depth;
- an internal program memory loadable through a write port;
- start and single-step control;
- a halt encoding;
- a zero register;
- a memory-mapped output port with a valid strobe.

Debug outputs keep the `opc`/`oacc`/`omem`/`oop1`/`osub` observation set, so existing benches can display them.

## Interface
Parameters:
- `WIDTH`, 8: data and instruction word width. Must be ≥ `$clog2(DEPTH)`.
- `DEPTH`, 16: memory words. Must be a power of two; `AW = $clog2(DEPTH)`.
- `START_PC`, 2: PC value after reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin free-running execution. Sampled only in IDLE.
- `step` in 1: execute exactly one instruction. Sampled only in IDLE; `start` has priority.
- `prog_we` in 1: program-memory write enable. Honoured only in IDLE or HALTED.
- `prog_addr` in AW: program write address.
- `prog_data` in WIDTH: program write data.
- `busy` out 1: high in FETCH, READ and EXEC.
- `halted` out 1: high in HALTED.
- `out_valid` out 1: one-cycle strobe on a write to address 1.
- `out_data` out WIDTH: value written to address 1. Held until the next strobe.
- `opc` out AW: current PC.
- `oacc` out WIDTH: accumulator.
- `oop1` out AW: operand address of the last fetched instruction.
- `omem` out WIDTH: operand value read.
- `osub` out WIDTH: last subtraction result.
- `icount` out 16: count of instructions executed. Wraps.

## Operation
- Memory is `DEPTH` × `WIDTH` registers. Each instruction is one word; its operand address is `word[AW-1:0]`, and the upper bits are ignored.
- Address 0 is the zero register:
  - operand reads return 0;
  - EXEC writes to it are discarded;
  - `prog_we` to address 0 is ignored;
  - instruction fetch from address 0 reads the raw array.
- Address 1 is the output port. An EXEC write to it updates memory, loads `out_data`, and pulses `out_valid`.
- State sequence: IDLE → FETCH → READ → EXEC, then back to FETCH (run mode) or to IDLE (step mode). HALTED is terminal.
- **FETCH:**
  - latch `word = mem[pc]`;
  - if `word == {WIDTH{1'b1}}`, go to HALTED (no state other than the FSM changes, `icount` not incremented);
  - otherwise `oop1 <= word[AW-1:0]`.
- **READ:** `omem <= (oop1==0) ? 0 : mem[oop1]`.
- **EXEC:**
  - `diff = omem - oacc`, modulo 2^WIDTH;
  - `borrow = (omem < oacc)`, unsigned;
  - `osub <= diff`, `oacc <= diff`, `mem[oop1] <= diff` (unless `oop1==0`);
  - `pc <= pc + (borrow ? 2 : 1)`, modulo `DEPTH`;
  - `icount++`.
- HALTED exits only via `rst`. `start` and `step` are ignored; `prog_we` is accepted.
- Run mode continues until halt or reset. There is no pause input.
- Reset state:
  - FSM IDLE, `pc = START_PC`;
  - `oacc`, `oop1`, `omem`, `osub`, `out_data`, `icount` = 0;
  - `busy`, `halted`, `out_valid` = 0;
  - memory contents are NOT cleared.
- Reset mid-instruction aborts it: no memory write and no PC update occur for the aborted instruction.

## Timing
- 3 cycles per instruction: FETCH, READ, EXEC.
- `start` or `step` sampled high in IDLE at edge n puts the FSM in FETCH at n+1.
- The EXEC results (`oacc`, `osub`, `opc`, memory, `icount`, `out_valid`) are visible after edge n+3.
- `out_valid` is high exactly in the cycle following the EXEC edge.
- `halted` rises one cycle after the FETCH that sees the halt word.
- `prog_we` writes land at the next edge. A write and a `start` in the same IDLE cycle: the write is performed and execution starts, and the first fetch sees the new data.
- `rst` overrides everything at the edge, including a simultaneous `prog_we`, which is dropped.

## Test plan
All scenarios use `WIDTH=8`, `DEPTH=16`.
- **Basic no-borrow step:** load `mem[2]=8`, `mem[8]=5`; pulse `step`. Required:
  - `busy` high for 3 cycles;
  - `oacc=5`, `osub=5`, `mem[8]=5`, `opc=3`, `icount=1`;
  - FSM back in IDLE.
- **Borrow and skip:** continue with `mem[3]=9`, `mem[9]=3`; step. Required: `osub=oacc=0xFE`, borrow, `opc=5`, `mem[9]=0xFE`.
- **Zero register:** with `oacc=2`, execute operand 0. Required:
  - `osub=0xFE`, `opc` advances by 2;
  - a later operand read of address 0 still returns 0;
  - `prog_we` to address 0 is ignored.
- **Output port:** reset, `mem[2]=1`, `mem[1]=7`; step. Required: `out_valid` high for exactly one cycle with `out_data=7`; `mem[1]=7`.
- **Run to halt:** program at addresses 2–4 followed by `0xFF` at 5; pulse `start`. Required:
  - `halted=1` and `busy=0`;
  - `icount` equals the number of executed instructions;
  - further `start`/`step` pulses change nothing;
  - `prog_we` still writes.
- **PC wrap and mid-instruction reset:**
  - PC wrap: `pc=15` with no borrow leads to `opc=0`; `pc=15` with borrow leads to `opc=1`.
  - Mid-instruction reset: asserting `rst` during READ leaves operand memory unchanged, sets `opc=2`, and zeroes all outputs.
